// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : timer_pkg                                                     |
// | Description: Shared encodings for the countdown-timer display formatter:   |
// |              timer state codes, display digit-code field positions, the    |
// |              blank digit, saturation limits and the BCD converter FSM.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package timer_pkg;

  // Timer state encodings as delivered by the timer core (2'b11 acts as idle)
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  // Display digit code: {enable, hex[3:0], decimal point}
  localparam int EN_BIT  = 5;
  localparam int HEX_MSB = 4;
  localparam int HEX_LSB = 1;
  localparam int DP_BIT  = 0;
  localparam logic [5:0] BLANK = 6'b000000;

  // Largest values the four-digit MM:SS display can show
  localparam logic [6:0] MIN_LIMIT = 7'd99;
  localparam logic [6:0] SEC_LIMIT = 7'd59;

  // One double-dabble iteration per input bit
  localparam int BCD_ITERS = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } conv_state_t;

  function automatic logic [6:0] saturate(input logic [6:0] value, input logic [6:0] limit);
    return (value > limit) ? limit : value;
  endfunction

  function automatic logic [5:0] digit_code(input logic en, input logic [3:0] hex, input logic dp);
    logic [5:0] code;
    code                  = BLANK;
    code[EN_BIT]          = en;
    code[HEX_MSB:HEX_LSB] = hex;
    code[DP_BIT]          = dp;
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : bin2bcd_seq                                                   |
// | Description: Iterative 7-bit binary to 2-digit BCD converter (double       |
// |              dabble), one iteration per clock. Inputs are expected to be   |
// |              <= 99 so the result fits in two BCD digits.                   |
// | Ports      : clock, reset (sync, active-low), start (loads bin),           |
// |              bin[6:0], busy (iterating), done (final iteration this cycle; |
// |              tens/units are valid from the following cycle), tens, units. |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bin2bcd_seq
  import timer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units
);

  localparam logic [2:0] LAST_ITER = 3'(BCD_ITERS - 1);

  logic [6:0]  bin_sh;
  logic [7:0]  bcd;
  logic [2:0]  iter;
  logic        running;
  logic [3:0]  tens_adj;
  logic [3:0]  units_adj;
  logic [14:0] work_shifted;

  // Add-3 correction on any nibble >= 5, then shift the whole
  // {bcd, binary} work register left by one.
  always_comb begin
    units_adj    = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    tens_adj     = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    work_shifted = {tens_adj, units_adj, bin_sh} << 1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bin_sh  <= '0;
      bcd     <= '0;
      iter    <= '0;
      running <= 1'b0;
    end else if (start) begin
      bin_sh  <= bin;
      bcd     <= '0;
      iter    <= '0;
      running <= 1'b1;
    end else if (running) begin
      bcd    <= work_shifted[14:7];
      bin_sh <= work_shifted[6:0];
      iter   <= iter + 3'd1;
      if (iter == LAST_ITER) begin
        running <= 1'b0;
      end
    end
  end

  assign busy  = running;
  assign done  = running && (iter == LAST_ITER);
  assign tens  = bcd[7:4];
  assign units = bcd[3:0];

endmodule
`default_nettype wire

// File: rtl/timer_digit_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : timer_digit_fmt                                               |
// | Description: Formats the countdown timer's minutes/seconds into eight      |
// |              display digit codes (MM:SS plus a status digit), with         |
// |              saturation, sequential BCD conversion and pause/done blink.   |
// | Ports      : clock, reset (sync, active-low), min_left[6:0],               |
// |              sec_left[6:0], state[1:0], done, d1..d8[5:0] digit codes      |
// |              {en, hex[3:0], dp}, busy (conversion in progress).            |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module timer_digit_fmt
  import timer_pkg::*;
#(
  parameter int BLINK_COUNT = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] min_left,
  input  logic [6:0] sec_left,
  input  logic [1:0] state,
  input  logic       done,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8,
  output logic       busy
);

  localparam int CNT_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_COUNT - 1);

  // ---------------------------------------------------------------------------
  // Conversion control
  // ---------------------------------------------------------------------------
  conv_state_t conv_state, conv_next;
  logic [6:0]  min_sat, sec_sat;
  logic [6:0]  cap_min, cap_sec;
  logic        pending;
  logic        in_changed;
  logic        start_conv;

  logic        min_busy, sec_busy, min_done, sec_done;
  logic [3:0]  min_tens, min_units, sec_tens, sec_units;
  logic [3:0]  dig_min_tens, dig_min_units, dig_sec_tens, dig_sec_units;

  assign min_sat    = saturate(min_left, MIN_LIMIT);
  assign sec_sat    = saturate(sec_left, SEC_LIMIT);
  assign in_changed = (min_sat != cap_min) || (sec_sat != cap_sec);

  always_ff @(posedge clock) begin
    if (!reset) begin
      conv_state <= IDLE;
    end else begin
      conv_state <= conv_next;
    end
  end

  // UPDATE chains straight into a new SHIFT when something changed while
  // busy, so back-to-back conversions have no idle gap.
  always_comb begin
    conv_next  = conv_state;
    start_conv = 1'b0;
    case (conv_state)
      IDLE: begin
        if (in_changed || pending) begin
          conv_next  = SHIFT;
          start_conv = 1'b1;
        end
      end
      SHIFT: begin
        if (min_done && sec_done) begin
          conv_next = UPDATE;
        end
      end
      UPDATE: begin
        if (in_changed || pending) begin
          conv_next  = SHIFT;
          start_conv = 1'b1;
        end else begin
          conv_next = IDLE;
        end
      end
      default: conv_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cap_min       <= '0;
      cap_sec       <= '0;
      pending       <= 1'b0;
      dig_min_tens  <= '0;
      dig_min_units <= '0;
      dig_sec_tens  <= '0;
      dig_sec_units <= '0;
    end else begin
      if (start_conv) begin
        cap_min <= min_sat;
        cap_sec <= sec_sat;
        pending <= 1'b0;
      end else if ((conv_state != IDLE) && in_changed) begin
        pending <= 1'b1;
      end
      if (conv_state == UPDATE) begin
        dig_min_tens  <= min_tens;
        dig_min_units <= min_units;
        dig_sec_tens  <= sec_tens;
        dig_sec_units <= sec_units;
      end
    end
  end

  bin2bcd_seq u_min_bcd (
    .clock (clock),
    .reset (reset),
    .start (start_conv),
    .bin   (min_sat),
    .busy  (min_busy),
    .done  (min_done),
    .tens  (min_tens),
    .units (min_units)
  );

  bin2bcd_seq u_sec_bcd (
    .clock (clock),
    .reset (reset),
    .start (start_conv),
    .bin   (sec_sat),
    .busy  (sec_busy),
    .done  (sec_done),
    .tens  (sec_tens),
    .units (sec_units)
  );

  // The converters are busy for exactly the SHIFT cycles; UPDATE adds one.
  assign busy = min_busy || sec_busy || (conv_state == UPDATE);

  // ---------------------------------------------------------------------------
  // Status and blink
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q;
  logic             done_q;
  logic             blink_active;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase_on;
  logic             visible;

  // Counter runs off the registered status so that entry into pause/done
  // always yields a full on half-period before the first off phase.
  assign blink_active = (state_q == ST_PAUSE) || done_q;
  assign visible      = !blink_active || phase_on;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else begin
      state_q <= state;
      done_q  <= done;
      if (!blink_active) begin
        blink_cnt <= '0;
        phase_on  <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase_on  <= !phase_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit codes
  // ---------------------------------------------------------------------------
  logic [3:0] status_val;

  always_comb begin
    status_val = 4'd0;
    if (done_q) begin
      status_val = 4'd3;
    end else if (state_q == ST_RUN) begin
      status_val = 4'd1;
    end else if (state_q == ST_PAUSE) begin
      status_val = 4'd2;
    end
  end

  assign d1 = digit_code(visible, dig_sec_units, 1'b0);
  assign d2 = digit_code(visible, dig_sec_tens, 1'b0);
  assign d3 = digit_code(visible, dig_min_units, 1'b1);   // dp acts as the colon
  assign d4 = digit_code(visible && (dig_min_tens != 4'd0), dig_min_tens, 1'b0);
  assign d5 = digit_code(1'b1, status_val, 1'b0);
  assign d6 = BLANK;
  assign d7 = BLANK;
  assign d8 = BLANK;

endmodule
`default_nettype wire

// File: tb/tb_timer_digit_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_timer_digit_fmt                                            |
// | Description: Scoreboard bench for timer_digit_fmt. The driver pushes the   |
// |              expected MM:SS codes (computed with divide/modulo) into a     |
// |              queue; a monitor pops one entry per completed conversion.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_timer_digit_fmt;

  logic       clock;
  logic       reset;
  logic [6:0] min_left;
  logic [6:0] sec_left;
  logic [1:0] state;
  logic       done;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  int last_m = 0;
  int last_s = 0;

  timer_digit_fmt #(.BLINK_COUNT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .min_left (min_left),
    .sec_left (sec_left),
    .state    (state),
    .done     (done),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .d4       (d4),
    .d5       (d5),
    .d6       (d6),
    .d7       (d7),
    .d8       (d8),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // {d4, d3, d2, d1} as shown with digits visible
  function automatic logic [23:0] exp_code(input int m, input int s);
    int ms, ss;
    logic [5:0] c1, c2, c3, c4;
    ms = sat(m, 99);
    ss = sat(s, 59);
    c4 = {(ms / 10) != 0, 4'(ms / 10), 1'b0};
    c3 = {1'b1, 4'(ms % 10), 1'b1};
    c2 = {1'b1, 4'(ss / 10), 1'b0};
    c1 = {1'b1, 4'(ss % 10), 1'b0};
    return {c4, c3, c2, c1};
  endfunction

  function automatic logic [5:0] exp_status(input logic [1:0] st, input logic dn);
    if (dn) return 6'b100110;
    if (st == 2'b01) return 6'b100010;
    if (st == 2'b10) return 6'b100100;
    return 6'b100000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- monitor ----------------
  // Each conversion occupies exactly 8 busy cycles; the new digits are on
  // the outputs one cycle after the eighth.
  initial begin
    int  bcnt = 0;
    bit  chk = 0;
    bit  prev_busy = 0;
    logic [23:0] want;
    forever begin
      @(negedge clock);
      if (!reset) begin
        bcnt = 0; chk = 0; prev_busy = 0;
      end else begin
        if (chk) begin
          chk = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: conversion result %h with empty expectation queue", {d4, d3, d2, d1});
          end else begin
            want = exp_q.pop_front();
            if ({d4, d3, d2, d1} !== want) begin
              errors++;
              $display("FAIL scoreboard digits: got %h expected %h at %0t", {d4, d3, d2, d1}, want, $time);
            end
          end
        end
        if (prev_busy && !busy) begin
          checks++;
          if (bcnt != 0) begin
            errors++;
            $display("FAIL busy length: busy dropped after %0d cycles of a conversion", bcnt);
          end
        end
        if (busy) begin
          bcnt++;
          if (bcnt == 8) begin bcnt = 0; chk = 1; end
        end
        prev_busy = busy;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic apply(input int m, input int s);
    min_left = 7'(m);
    sec_left = 7'(s);
    exp_q.push_back(exp_code(m, s));
    last_m = sat(m, 99);
    last_s = sat(s, 59);
  endtask

  // Call at a negedge with the DUT idle and (m1,s1) differing from the last
  // converted value. Optionally changes the inputs after k busy cycles.
  task automatic run_conv(input int m1, input int s1, input bit mid, input int k,
                          input int m2, input int s2);
    int n = 0;
    logic [23:0] prev;
    prev = exp_code(last_m, last_s);
    apply(m1, s1);
    @(negedge clock);
    while (busy && n < 40) begin
      n++;
      if (!mid && n == 8) check("no early update", {d4, d3, d2, d1}, prev);
      if (mid && n == k) apply(m2, s2);
      @(negedge clock);
    end
    check("busy cycles", n, mid ? 16 : 8);
  endtask

  task automatic ensure(input int m, input int s);
    if (sat(m, 99) != last_m || sat(s, 59) != last_s) run_conv(m, s, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " digits"}, {d4, d3, d2, d1}, exp_code(0, 0));
    check({tag, " d5"}, d5, 6'b100000);
    check({tag, " d6..d8"}, {d6, d7, d8}, 18'd0);
    check({tag, " busy"}, busy, 1'b0);
  endtask

  initial begin
    int m1, s1, m2, s2, k;
    bit mid;
    logic [1:0] st;
    logic [1:0] st_choices[3];
    st_choices[0] = 2'b00; st_choices[1] = 2'b01; st_choices[2] = 2'b11;

    reset = 1'b0; min_left = 7'd0; sec_left = 7'd0; state = 2'b00; done = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");

    // Release with 25:07
    reset = 1'b1;
    run_conv(25, 7, 0, 0, 0, 0);
    check("status idle", d5, 6'b100000);

    // Saturation
    run_conv(120, 75, 0, 0, 0, 0);

    // Change mid-conversion: 10:30 then 10:29 back to back
    run_conv(10, 30, 1, 3, 10, 29);

    // Pause blink with BLINK_COUNT=4
    state = 2'b01;
    ensure(25, 7);
    state = 2'b10;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      check("pause enables", {d4[5], d3[5], d2[5], d1[5]}, (((i - 1) / 4) % 2 == 0) ? 4'b1111 : 4'b0000);
      check("pause d5", d5, 6'b100100);
    end
    check("pause hex kept", {d4[4:1], d3[4:1], d2[4:1], d1[4:1]}, 16'h2507);
    state = 2'b01;
    @(negedge clock);
    check("resume enables", {d4[5], d3[5], d2[5], d1[5]}, 4'b1111);
    check("resume d5", d5, 6'b100010);

    // Done overrides running, 00:00
    ensure(0, 0);
    done = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      check("done d5", d5, 6'b100110);
      check("done d4 blank", d4, 6'b000000);
      check("done enables", {d3[5], d2[5], d1[5]}, (((i - 1) / 4) % 2 == 0) ? 3'b111 : 3'b000);
    end
    done = 1'b0;
    state = 2'b00;
    @(negedge clock);

    // Reset mid-conversion aborts (no expectation pushed)
    min_left = 7'd42; sec_left = 7'd17;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("abort");
    min_left = 7'd0; sec_left = 7'd0;
    last_m = 0; last_s = 0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("post abort");

    // Randomised conversions
    for (int it = 0; it < 15; it++) begin
      st = st_choices[$urandom_range(0, 2)];
      state = st;
      do begin
        m1 = $urandom_range(0, 127); s1 = $urandom_range(0, 127);
      end while (sat(m1, 99) == last_m && sat(s1, 59) == last_s);
      mid = ($urandom_range(0, 2) == 0);
      k = $urandom_range(1, 8);
      do begin
        m2 = $urandom_range(0, 127); s2 = $urandom_range(0, 127);
      end while (sat(m2, 99) == sat(m1, 99) && sat(s2, 59) == sat(s1, 59));
      run_conv(m1, s1, mid, k, m2, s2);
      check("random d5", d5, exp_status(st, 1'b0));
    end

    repeat (2) @(negedge clock);
    check("queue drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
